// File: rtl/pipelined_adder_pkg.sv
// ============================================================================
// pipelined_adder_pkg
// Purpose : Shared definitions for the pipelined adder/subtractor slice of the
//           datapath: default geometry, the operation encoding and a helper
//           that validates a WIDTH/STAGES pair at elaboration time.
// Ports   : none (package)
// ============================================================================
package pipelined_adder_pkg;

    localparam int DEFAULT_WIDTH  = 16;
    localparam int DEFAULT_STAGES = 4;

    // Operation requested on the input side; the sub input maps straight onto it.
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // A geometry is legal when both sizes are positive and the operand splits
    // into equal slices, one slice per pipeline stage.
    function automatic bit stage_config_ok(int width, int stages);
        if (width < 1 || stages < 1) begin
            return 1'b0;
        end
        return (width % stages) == 0;
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// ============================================================================
// pipelined_adder_if
// Purpose : Bundles the operand (input) and result (output) handshakes of the
//           pipelined adder.
// Signals : in_valid/in_ready  operand beat handshake
//           a, b, cin, sub     operands, carry-in and add/subtract select
//           out_valid/out_ready result beat handshake
//           sum, cout, ovf     result, carry out of MSB, signed overflow
// Modports: slave  - the adder itself
//           master - the producer/consumer side driving operands, taking results
// ============================================================================
interface pipelined_adder_if
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/pipelined_adder_slice.sv
// ============================================================================
// full_adder / adder_slice
// Purpose : Combinational building blocks of one pipeline stage. adder_slice
//           ripples a carry through SLICE full_adder cells.
// Ports   : full_adder  a, b, cin -> sum, cout
//           adder_slice a[SLICE], b[SLICE], cin -> sum[SLICE], cout,
//                       carry_msb (carry into the slice MSB, used for the
//                       signed-overflow flag of the top slice)
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module adder_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             carry_msb
);

    // The carry chain is SLICE+1 bits: bit 0 is the incoming carry, bit SLICE
    // is the carry leaving the slice.
    logic [SLICE:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout      = carry[SLICE];
    assign carry_msb = carry[SLICE-1];

endmodule

// File: rtl/pipelined_adder.sv
// ============================================================================
// pipelined_adder
// Purpose : Pipelined ripple-carry adder/subtractor. A WIDTH-bit add is split
//           into STAGES equal slices; each stage adds one slice using the carry
//           registered by the previous stage. Sustains one result per cycle.
// Ports   : clk  - clock, all state on the rising edge
//           rst  - synchronous active-high reset, empties the pipe
//           bus  - pipelined_adder_if.slave: operand handshake (in_valid,
//                  in_ready, a, b, cin, sub) and result handshake (out_valid,
//                  out_ready, sum, cout, ovf)
// ============================================================================
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    pipelined_adder_if.slave bus
);

    localparam int SLICE = (STAGES > 0) ? (WIDTH / STAGES) : 1;

    if (!stage_config_ok(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_adder: WIDTH must be >= 1, STAGES >= 1 and WIDTH a multiple of STAGES");
    end

    // Pipeline registers, one entry per stage. Each entry carries the operands
    // (upper slices still to be added), the sum bits completed so far, the
    // carry out of the slice just added and the beat's valid bit.
    logic [WIDTH-1:0]  a_q     [STAGES];
    logic [WIDTH-1:0]  a_d     [STAGES];
    logic [WIDTH-1:0]  b_q     [STAGES];
    logic [WIDTH-1:0]  b_d     [STAGES];
    logic [WIDTH-1:0]  sum_q   [STAGES];
    logic [WIDTH-1:0]  sum_d   [STAGES];
    logic [STAGES-1:0] carry_q;
    logic [STAGES-1:0] carry_d;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    logic              ovf_q;
    logic              ovf_d;

    // What each stage's adder sees: the live inputs for stage 0, the previous
    // stage's register for every later stage.
    logic [WIDTH-1:0]  stage_a   [STAGES];
    logic [WIDTH-1:0]  stage_b   [STAGES];
    logic [WIDTH-1:0]  stage_sum [STAGES];
    logic [STAGES-1:0] stage_cin;
    logic [STAGES-1:0] stage_valid;

    logic [WIDTH-1:0]  slice_sum;
    logic [STAGES-1:0] slice_cout;
    logic [STAGES-1:0] slice_cmsb;

    logic              advance;
    op_e               op;

    // The whole pipe moves together; it only holds when a result is waiting
    // and the consumer is not taking it.
    assign advance = !valid_q[STAGES-1] || bus.out_ready;

    // Subtraction is a + ~b + 1, so b is inverted once on capture and the
    // inverted copy travels down the pipe; cin is replaced by the +1.
    always_comb begin
        op = op_e'(bus.sub);
        for (int k = 0; k < STAGES; k++) begin
            stage_a[k]     = '0;
            stage_b[k]     = '0;
            stage_sum[k]   = '0;
            stage_cin[k]   = 1'b0;
            stage_valid[k] = 1'b0;
        end
        stage_a[0]     = bus.a;
        stage_b[0]     = (op == OP_SUB) ? ~bus.b : bus.b;
        stage_cin[0]   = (op == OP_SUB) ? 1'b1 : bus.cin;
        stage_valid[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            stage_a[k]     = a_q[k-1];
            stage_b[k]     = b_q[k-1];
            stage_sum[k]   = sum_q[k-1];
            stage_cin[k]   = carry_q[k-1];
            stage_valid[k] = valid_q[k-1];
        end
    end

    // One ripple slice per stage, each working on its own bit range.
    for (genvar k = 0; k < STAGES; k++) begin : g_slice
        adder_slice #(
            .SLICE (SLICE)
        ) u_slice (
            .a         (stage_a[k][k*SLICE +: SLICE]),
            .b         (stage_b[k][k*SLICE +: SLICE]),
            .cin       (stage_cin[k]),
            .sum       (slice_sum[k*SLICE +: SLICE]),
            .cout      (slice_cout[k]),
            .carry_msb (slice_cmsb[k])
        );
    end

    // Next register contents: pass operands along, drop the freshly computed
    // slice into the running sum, and keep the carry for the next stage.
    // Overflow only means something once the top slice is done.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            a_d[k]                      = stage_a[k];
            b_d[k]                      = stage_b[k];
            sum_d[k]                    = stage_sum[k];
            sum_d[k][k*SLICE +: SLICE]  = slice_sum[k*SLICE +: SLICE];
            carry_d[k]                  = slice_cout[k];
            valid_d[k]                  = stage_valid[k];
        end
        ovf_d = slice_cmsb[STAGES-1] ^ slice_cout[STAGES-1];
    end

    // Reset clears valid bits and data so nothing from before reset can ever
    // surface; otherwise the pipe shifts on advance and holds on a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
            carry_q <= '0;
            valid_q <= '0;
            ovf_q   <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
            carry_q <= carry_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.sum       = sum_q[STAGES-1];
    assign bus.cout      = carry_q[STAGES-1];
    assign bus.ovf       = ovf_q;

endmodule
